// File: rtl/sprite_fetch_sched.sv
// rtl/sprite_fetch_sched.sv - round-robin sprite ROM fetch scheduler with animation frame counter
module sprite_fetch_sched #(
    parameter int NUM_REQ     = 4,
    parameter int SPRITE_W    = 45,
    parameter int SPRITE_H    = 45,
    parameter int OFS_W       = 11,
    parameter int ROM_AW      = 12,
    parameter int HALF_PERIOD = 12500000,
    parameter int CNT_W       = 24,
    localparam int ID_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                     Clk,
    input  logic                     Reset,
    input  logic                     anim_en,
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*OFS_W-1:0] req_offset,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [ROM_AW-1:0]        rom_addr,
    input  logic [23:0]              rom_data,
    output logic                     rsp_valid,
    output logic [ID_W-1:0]          rsp_id,
    output logic [23:0]              rsp_data,
    output logic                     frame
);

    localparam int unsigned         SPRITE_PIX = SPRITE_W * SPRITE_H;
    localparam logic [ROM_AW-1:0]   FRAME_BASE = ROM_AW'(SPRITE_PIX);
    localparam logic [CNT_W-1:0]    CNT_LAST   = CNT_W'(HALF_PERIOD - 1);
    localparam logic [ID_W-1:0]     ID_LAST    = ID_W'(NUM_REQ - 1);

    logic [CNT_W-1:0]  r_cnt;
    logic              r_frame;
    logic [ID_W-1:0]   r_rr_ptr;
    logic [ROM_AW-1:0] r_rom_addr;
    logic              r_s1_valid;
    logic [ID_W-1:0]   r_s1_id;
    logic              r_s1_oob;
    logic              r_s2_valid;
    logic [ID_W-1:0]   r_s2_id;
    logic              r_s2_oob;

    logic [NUM_REQ-1:0] w_gnt;
    logic               w_gnt_any;
    logic [ID_W-1:0]    w_gnt_idx;
    logic [OFS_W-1:0]   w_sel_ofs;
    logic               w_oob;
    logic [ROM_AW-1:0]  w_rom_addr_nxt;
    logic [ID_W-1:0]    w_rr_ptr_nxt;

    // Single free-running counter shared by every sprite; frame flips once per half period.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_cnt   <= '0;
            r_frame <= 1'b0;
        end else if (anim_en) begin
            if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_frame <= ~r_frame;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    // Scan from the round-robin pointer upward; first requester found wins.
    always_comb begin
        int idx;
        idx       = 0;
        w_gnt     = '0;
        w_gnt_any = 1'b0;
        w_gnt_idx = '0;
        w_sel_ofs = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_gnt_any && req[idx]) begin
                w_gnt_any = 1'b1;
                w_gnt[idx] = 1'b1;
                w_gnt_idx = ID_W'(idx);
                w_sel_ofs = req_offset[idx*OFS_W +: OFS_W];
            end
        end
    end

    always_comb begin
        w_oob          = (32'(w_sel_ofs) >= SPRITE_PIX);
        w_rom_addr_nxt = (r_frame ? FRAME_BASE : '0) + (w_oob ? '0 : ROM_AW'(w_sel_ofs));
        w_rr_ptr_nxt   = (w_gnt_idx == ID_LAST) ? '0 : w_gnt_idx + ID_W'(1);
    end

    // Out-of-range reads still touch the frame base so the ROM sees a legal address.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            r_rr_ptr   <= '0;
            r_rom_addr <= '0;
            r_s1_valid <= 1'b0;
            r_s1_id    <= '0;
            r_s1_oob   <= 1'b0;
            r_s2_valid <= 1'b0;
            r_s2_id    <= '0;
            r_s2_oob   <= 1'b0;
        end else begin
            r_s1_valid <= w_gnt_any;
            if (w_gnt_any) begin
                r_s1_id    <= w_gnt_idx;
                r_s1_oob   <= w_oob;
                r_rom_addr <= w_rom_addr_nxt;
                r_rr_ptr   <= w_rr_ptr_nxt;
            end
            r_s2_valid <= r_s1_valid;
            r_s2_id    <= r_s1_id;
            r_s2_oob   <= r_s1_oob;
        end
    end

    always_comb begin
        gnt       = w_gnt;
        rom_addr  = r_rom_addr;
        frame     = r_frame;
        rsp_valid = r_s2_valid;
        rsp_id    = r_s2_id;
        rsp_data  = 24'h000000;
        if (r_s2_valid) begin
            rsp_data = r_s2_oob ? 24'hFFFFFF : rom_data;
        end
    end

endmodule

// File: tb/tb_sprite_fetch_sched.sv
// tb/tb_sprite_fetch_sched.sv - directed self-checking bench for sprite_fetch_sched
module tb_sprite_fetch_sched;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        anim_en;
    logic [3:0]  req;
    logic [43:0] req_offset;
    logic [3:0]  gnt;
    logic [11:0] rom_addr;
    logic [23:0] rom_data;
    logic        rsp_valid;
    logic [1:0]  rsp_id;
    logic [23:0] rsp_data;
    logic        frame;

    int checks = 0;
    int errors = 0;

    sprite_fetch_sched #(.HALF_PERIOD(4)) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .anim_en    (anim_en),
        .req        (req),
        .req_offset (req_offset),
        .gnt        (gnt),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_data   (rsp_data),
        .frame      (frame)
    );

    always #5 Clk = ~Clk;

    function automatic logic [23:0] rom_word(input logic [11:0] a);
        return (a == 12'd0) ? 24'h123456 : {~a, a};
    endfunction

    // Synchronous-read ROM model.
    always_ff @(posedge Clk) rom_data <= rom_word(rom_addr);

    task automatic set_ofs(input int i, input int v);
        req_offset[i*11 +: 11] = 11'(v);
    endtask

    task automatic next_cycle();
        @(posedge Clk);
        #1;
    endtask

    task automatic do_reset();
        Reset = 1'b1; req = 4'b0; anim_en = 1'b0; req_offset = '0;
        next_cycle();
        next_cycle();
        Reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        @(negedge Clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %b exp 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d exp 0", rsp_id); end
        checks++; if (rsp_data !== 24'h0) begin errors++; $display("FAIL reset_rsp_data: got %h exp 000000", rsp_data); end
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL reset_frame: got %b exp 0", frame); end
        checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL reset_rom_addr: got %0d exp 0", rom_addr); end
        checks++; if (gnt !== 4'b0) begin errors++; $display("FAIL reset_gnt_idle: got %b exp 0000", gnt); end
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0001; set_ofs(0, 0);
        @(negedge Clk);
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL single_gnt: got %b exp 0001", gnt); end
        next_cycle();
        req = 4'b0;
        @(negedge Clk);
        checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL single_rom_addr: got %0d exp 0", rom_addr); end
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_valid: got %b exp 0", rsp_valid); end
        next_cycle();
        @(negedge Clk);
        checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL single_rsp_valid: got %b exp 1", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL single_rsp_id: got %0d exp 0", rsp_id); end
        checks++; if (rsp_data !== 24'h123456) begin errors++; $display("FAIL single_rsp_data: got %h exp 123456", rsp_data); end
        next_cycle();
        @(negedge Clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_valid_drop: got %b exp 0", rsp_valid); end
    endtask

    task automatic test_round_robin();
        logic [3:0]  exp_g;
        logic [1:0]  exp_id;
        logic [11:0] exp_a;
        do_reset();
        for (int i = 0; i < 4; i++) set_ofs(i, 100 + i);
        for (int c = 0; c < 10; c++) begin
            req = (c < 8) ? 4'hF : 4'h0;
            @(negedge Clk);
            exp_g = (c < 8) ? 4'(1 << (c % 4)) : 4'h0;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rr_gnt c%0d: got %b exp %b", c, gnt, exp_g); end
            if (c >= 1 && c <= 8) begin
                exp_a = 12'(100 + (c - 1) % 4);
                checks++; if (rom_addr !== exp_a) begin errors++; $display("FAIL rr_rom_addr c%0d: got %0d exp %0d", c, rom_addr, exp_a); end
            end
            if (c >= 2) begin
                exp_id = 2'((c - 2) % 4);
                exp_a  = 12'(100 + (c - 2) % 4);
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id || rsp_data !== rom_word(exp_a)) begin
                    errors++; $display("FAIL rr_rsp c%0d: got v=%b id=%0d d=%h exp v=1 id=%0d d=%h", c, rsp_valid, rsp_id, rsp_data, exp_id, rom_word(exp_a));
                end
            end else begin
                checks++; if (rsp_valid !== 1'b0 || rsp_data !== 24'h0) begin errors++; $display("FAIL rr_rsp_idle c%0d: got v=%b d=%h exp v=0 d=000000", c, rsp_valid, rsp_data); end
            end
            next_cycle();
        end
    endtask

    task automatic test_anim();
        logic        exp_f;
        logic [11:0] exp_a;
        do_reset();
        anim_en = 1'b1; req = 4'b0001; set_ofs(0, 10);
        for (int c = 0; c < 12; c++) begin
            @(negedge Clk);
            exp_f = 1'((c / 4) % 2);
            checks++; if (frame !== exp_f) begin errors++; $display("FAIL anim_frame c%0d: got %b exp %b", c, frame, exp_f); end
            if (c >= 1) begin
                exp_a = 12'(10 + ((c - 1) / 4) % 2 * 2025);
                checks++; if (rom_addr !== exp_a) begin errors++; $display("FAIL anim_rom_addr c%0d: got %0d exp %0d", c, rom_addr, exp_a); end
            end
            if (c >= 2) begin
                exp_a = 12'(10 + ((c - 2) / 4) % 2 * 2025);
                checks++; if (rsp_data !== rom_word(exp_a)) begin errors++; $display("FAIL anim_rsp_data c%0d: got %h exp %h", c, rsp_data, rom_word(exp_a)); end
            end
            next_cycle();
        end
        req = 4'b0; anim_en = 1'b0;
    endtask

    task automatic test_oob();
        do_reset();
        anim_en = 1'b1;
        repeat (4) next_cycle();
        anim_en = 1'b0; req = 4'b0100; set_ofs(2, 2025);
        @(negedge Clk);
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL oob_frame: got %b exp 1", frame); end
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL oob_gnt2: got %b exp 0100", gnt); end
        next_cycle();
        req = 4'b0010; set_ofs(1, 2024);
        @(negedge Clk);
        checks++; if (rom_addr !== 12'd2025) begin errors++; $display("FAIL oob_rom_addr: got %0d exp 2025", rom_addr); end
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL oob_gnt1: got %b exp 0010", gnt); end
        next_cycle();
        req = 4'b0;
        @(negedge Clk);
        checks++; if (rom_addr !== 12'd4049) begin errors++; $display("FAIL edge_rom_addr: got %0d exp 4049", rom_addr); end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 24'hFFFFFF) begin
            errors++; $display("FAIL oob_rsp: got v=%b id=%0d d=%h exp v=1 id=2 d=ffffff", rsp_valid, rsp_id, rsp_data);
        end
        next_cycle();
        @(negedge Clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== rom_word(12'd4049)) begin
            errors++; $display("FAIL edge_rsp: got v=%b id=%0d d=%h exp v=1 id=1 d=%h", rsp_valid, rsp_id, rsp_data, rom_word(12'd4049));
        end
        next_cycle();
        @(negedge Clk);
        checks++; if (rsp_valid !== 1'b0 || rsp_data !== 24'h0) begin errors++; $display("FAIL oob_idle: got v=%b d=%h exp v=0 d=000000", rsp_valid, rsp_data); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        anim_en = 1'b1; req = 4'b0010; set_ofs(1, 5);
        @(negedge Clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt: got %b exp 0010", gnt); end
        next_cycle();
        req = 4'b0; Reset = 1'b1;
        next_cycle();
        Reset = 1'b0;
        for (int c = 2; c < 5; c++) begin
            @(negedge Clk);
            checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL mid_rsp_valid c%0d: got %b exp 0", c, rsp_valid); end
            checks++; if (frame !== 1'b0) begin errors++; $display("FAIL mid_frame c%0d: got %b exp 0", c, frame); end
            if (c == 2) begin
                checks++; if (rom_addr !== 12'd0) begin errors++; $display("FAIL mid_rom_addr: got %0d exp 0", rom_addr); end
            end
            next_cycle();
        end
        req = 4'b1010; set_ofs(1, 7); set_ofs(3, 9);
        @(negedge Clk);
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL mid_gnt_after: got %b exp 0010", gnt); end
        checks++; if (frame !== 1'b0) begin errors++; $display("FAIL mid_frame c5: got %b exp 0", frame); end
        next_cycle();
        req = 4'b0;
        @(negedge Clk);
        checks++; if (frame !== 1'b1) begin errors++; $display("FAIL mid_frame c6: got %b exp 1", frame); end
        checks++; if (rom_addr !== 12'd7) begin errors++; $display("FAIL mid_pretoggle_addr: got %0d exp 7", rom_addr); end
        next_cycle();
        @(negedge Clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd1 || rsp_data !== rom_word(12'd7)) begin
            errors++; $display("FAIL mid_rsp: got v=%b id=%0d d=%h exp v=1 id=1 d=%h", rsp_valid, rsp_id, rsp_data, rom_word(12'd7));
        end
        anim_en = 1'b0;
    endtask

    task automatic test_anim_hold();
        logic exp_f;
        do_reset();
        for (int c = 0; c < 16; c++) begin
            anim_en = (c < 2 || c >= 12) ? 1'b1 : 1'b0;
            @(negedge Clk);
            exp_f = (c >= 14) ? 1'b1 : 1'b0;
            checks++; if (frame !== exp_f) begin errors++; $display("FAIL hold_frame c%0d: got %b exp %b", c, frame, exp_f); end
            next_cycle();
        end
        anim_en = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g;
        do_reset();
        for (int k = 0; k < 6; k++) begin
            req = (k < 4) ? 4'b0001 : 4'b0000;
            set_ofs(0, 20 + k);
            @(negedge Clk);
            exp_g = (k < 4) ? 4'b0001 : 4'b0000;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL b2b_gnt k%0d: got %b exp %b", k, gnt, exp_g); end
            if (k >= 2) begin
                checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd0 || rsp_data !== rom_word(12'(20 + k - 2))) begin
                    errors++; $display("FAIL b2b_rsp k%0d: got v=%b id=%0d d=%h exp v=1 id=0 d=%h", k, rsp_valid, rsp_id, rsp_data, rom_word(12'(20 + k - 2)));
                end
            end
            next_cycle();
        end
    endtask

    initial begin
        Reset = 1'b1; req = 4'b0; anim_en = 1'b0; req_offset = '0;
        #1;
        test_reset();
        test_single();
        test_round_robin();
        test_anim();
        test_oob();
        test_reset_mid();
        test_anim_hold();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sprite_fetch_sched.md
Name: sprite_fetch_sched

Overview:
- Shares one synchronous-read, two-frame monster sprite ROM between NUM_REQ draw requesters using a round-robin arbiter.
- Owns the animation frame counter, replacing per-memory timestamp modulo logic with a single free-running half-period toggle.
- Builds the ROM read address from frame and pixel offset, and returns tagged pixel data with fixed latency.
- Sits between the per-monster draw logic and the sprite ROM inside the color mapper path.

Parameters:
NUM_REQ, 4, number of requesters
SPRITE_W, 45, sprite width in pixels
SPRITE_H, 45, sprite height in pixels
OFS_W, 11, width of one requester's pixel offset
ROM_AW, 12, ROM address width
HALF_PERIOD, 12500000, clocks per animation frame
CNT_W, 24, frame counter width

Ports:
Clk  input  1  system clock
Reset  input  1  synchronous active-high reset
anim_en  input  1  frame counter advances while 1
req  input  NUM_REQ  per-requester read request, level
req_offset  input  NUM_REQ*OFS_W  flattened offsets; requester i occupies [i*OFS_W +: OFS_W]
gnt  output  NUM_REQ  one-hot grant, combinational
rom_addr  output  ROM_AW  registered read address to ROM
rom_data  input  24  ROM read data, valid one clock after rom_addr
rsp_valid  output  1  response pixel valid
rsp_id  output  $clog2(NUM_REQ)  requester index of response
rsp_data  output  24  pixel, 24'hFFFFFF for out-of-range
frame  output  1  current animation frame

Behaviour:
- Reset (synchronous, Clk edge with Reset=1): cnt=0, frame=0, rr_ptr=0, rom_addr=0, all pipeline valid bits=0, rsp_valid=0, rsp_id=0, rsp_data=0.
- Reset asserted mid-operation discards all in-flight requests. rsp_valid is 0 in the cycle after the reset edge.
- Frame counter:
  - If anim_en=1: cnt increments. When cnt==HALF_PERIOD-1, cnt wraps to 0 and frame toggles.
  - If anim_en=0: cnt and frame hold.
- Arbiter:
  - gnt is combinational. It selects the first i with req[i]=1, scanning from rr_ptr upward modulo NUM_REQ.
  - gnt is all-zero when req is zero.
  - At most one bit of gnt is set.
  - On a grant to i, rr_ptr <= (i+1) mod NUM_REQ at the clock edge. Otherwise rr_ptr holds.
- Handshake:
  - A requester holds req and its offset stable until it sees its gnt bit high at a clock edge. The transfer completes on that edge.
  - A requester may keep req high to issue back-to-back reads.
  - Throughput: one grant per cycle.
- Stage 1 (edge ending grant cycle T):
  - s1_valid <= |gnt; s1_id <= granted index.
  - s1_oob <= (offset >= SPRITE_W*SPRITE_H).
  - rom_addr <= frame*SPRITE_W*SPRITE_H + (oob ? 0 : offset), using frame as sampled in cycle T.
  - Arithmetic is unsigned and zero-extended to ROM_AW.
- Stage 2 (edge ending T+1): s2_valid, s2_id, s2_oob <= stage 1 values. The ROM presents rom_data for rom_addr during T+2.
- Output, combinational from stage 2 in cycle T+2:
  - rsp_valid=s2_valid; rsp_id=s2_id.
  - rsp_data = s2_oob ? 24'hFFFFFF : rom_data.
  - rsp_data is driven as 24'h000000 when s2_valid=0.
- Latency is exactly 2 clocks from grant edge to rsp_valid.
- Ordering: responses return in grant order. There is no backpressure, so requesters must accept a response in its valid cycle.
- Frame toggling in the same cycle as a grant: the request uses the pre-toggle frame, i.e. the frame value visible during the grant cycle.
- When rom_addr is not updated (no grant), it holds its previous value.

Test Plan:
- Reset, then req=4'b0001 with offset 0, frame=0, ROM word0=0x123456 → gnt=0001 in the same cycle; rom_addr=0 one cycle later; rsp_valid=1, rsp_id=0, rsp_data=0x123456 two cycles after the grant edge.
- req=4'b1111 held for 8 cycles → grants follow 0,1,2,3,0,1,2,3, one per cycle; rsp_id follows the same sequence delayed by 2.
- HALF_PERIOD=4, anim_en=1, offset 10 requested every cycle → frame toggles every 4 cycles; rom_addr alternates between 10 and 2035 in runs of 4.
- Offset 2025 (out of range) on requester 2 → rom_addr = frame base; rsp_data=0xFFFFFF, rsp_id=2.
- Reset asserted one cycle after a grant → rsp_valid stays 0 for the next 3 cycles; frame=0, cnt=0, and the next grant goes to the lowest requesting index.
- anim_en=0 for 10 cycles with HALF_PERIOD=4 → frame constant; it resumes toggling 4 cycles after anim_en returns to 1 if cnt was 0.
